axi_read_arbiter: RTL and testbench

//  Round-robin arbiter for the shared AXI read-address channel of the interconnect.

---
 rtl/axi_read_arbiter_pkg.sv | 21 ++
 rtl/axi_read_arbiter_if.sv | 38 +++
 rtl/axi_read_arbiter_rr_pick3.sv | 32 +++
 rtl/axi_read_arbiter.sv | 117 +++++++++++
 tb/tb_axi_read_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and constants for the AXI read-address arbiter.
// Holds the state encoding, the grant vector type and the round-robin pointer helper.
package axi_read_arbiter_pkg;

  localparam int unsigned NUM_MST  = 3;
  localparam int unsigned LEN_BITS = 8;

  typedef logic [NUM_MST-1:0] grant_t;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } arb_state_e;

  // Priority moves to the master just after the winner, wrapping at NUM_MST.
  function automatic logic [1:0] next_ptr(input logic [1:0] idx);
    return (idx == 2'(NUM_MST - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Request, handshake and grant signals shared between the arbiter and the AR/R datapath.
// The slave modport is the arbiter's view; master is the datapath/driver view.
interface axi_read_arbiter_if #(
  parameter int unsigned LEN_W = axi_read_arbiter_pkg::LEN_BITS
) ();

  logic             m0_arvalid;
  logic             m1_arvalid;
  logic             m2_arvalid;
  logic             arvalid;
  logic             arready;
  logic [LEN_W-1:0] arlen;
  logic             rvalid;
  logic             rready;
  logic             rlast;
  logic             m0_rgrnt;
  logic             m1_rgrnt;
  logic             m2_rgrnt;
  logic             busy;
  logic             len_err;

  modport slave (
    input  m0_arvalid, m1_arvalid, m2_arvalid,
    input  arvalid, arready, arlen,
    input  rvalid, rready, rlast,
    output m0_rgrnt, m1_rgrnt, m2_rgrnt,
    output busy, len_err
  );

  modport master (
    output m0_arvalid, m1_arvalid, m2_arvalid,
    output arvalid, arready, arlen,
    output rvalid, rready, rlast,
    input  m0_rgrnt, m1_rgrnt, m2_rgrnt,
    input  busy, len_err
  );

endinterface

// File: rtl/axi_read_arbiter_rr_pick3.sv
// Combinational rotating-priority picker for three requesters.
// Searches upward from ptr (wrapping) and returns the first requester as one-hot plus index.
module axi_read_arbiter_rr_pick3
  import axi_read_arbiter_pkg::*;
(
  input  grant_t     req,
  input  logic [1:0] ptr,
  output grant_t     gnt,
  output logic [1:0] idx
);

  always_comb begin
    logic       found;
    logic [1:0] cidx;
    int         c;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cidx  = '0;
    c     = 0;
    for (int k = 0; k < int'(NUM_MST); k++) begin
      c    = (int'(ptr) + k) % int'(NUM_MST);
      cidx = 2'(c);
      if (!found && req[cidx]) begin
        found     = 1'b1;
        gnt[cidx] = 1'b1;
        idx       = cidx;
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin owner of the shared AR channel; holds the grant through the read burst
// (optionally) and flags bursts whose beat count disagrees with the captured ARLEN.
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter bit          LOCK_UNTIL_RLAST = 1'b1,
  parameter int unsigned LEN_W            = LEN_BITS
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  axi_read_arbiter_if.slave       bus
);

  arb_state_e       state_q, state_d;
  grant_t           grant_q, grant_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             over_q, over_d;
  logic             len_err_q, len_err_d;

  grant_t     req;
  grant_t     pick_gnt;
  logic [1:0] pick_idx;
  logic       ar_hs;
  logic       r_beat;
  logic       beat_max;

  assign req      = {bus.m2_arvalid, bus.m1_arvalid, bus.m0_arvalid};
  assign ar_hs    = bus.arvalid & bus.arready;
  assign r_beat   = bus.rvalid & bus.rready;
  assign beat_max = (beat_cnt_q == '1);

  axi_read_arbiter_rr_pick3 u_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    over_d     = over_q;
    len_err_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d  = pick_gnt;
          rr_ptr_d = next_ptr(pick_idx);
          state_d  = StAddr;
        end
      end
      StAddr: begin
        if (ar_hs) begin
          len_d      = bus.arlen;
          beat_cnt_d = '0;
          over_d     = 1'b0;
          if (LOCK_UNTIL_RLAST) begin
            state_d = StData;
          end else begin
            grant_d = '0;
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (r_beat) begin
          if (!beat_max) beat_cnt_d = beat_cnt_q + LEN_W'(1);
          // An overrun already reported suppresses a second pulse at RLAST.
          if (bus.rlast) begin
            len_err_d = !over_q && (beat_cnt_q != len_q);
            grant_d   = '0;
            state_d   = StIdle;
          end else if (!over_q && (beat_cnt_q == len_q)) begin
            len_err_d = 1'b1;
            over_d    = 1'b1;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      over_q     <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      over_q     <= over_d;
      len_err_q  <= len_err_d;
    end
  end

  assign bus.m0_rgrnt = grant_q[0];
  assign bus.m1_rgrnt = grant_q[1];
  assign bus.m2_rgrnt = grant_q[2];
  assign bus.busy     = (state_q != StIdle);
  assign bus.len_err  = len_err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench: directed cycle tables, hand-written corner sequences and a randomized
// run compared against a transaction-level model of both lock modes.
module tb_axi_read_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  axi_read_arbiter_if #(.LEN_W(8)) bus_l ();
  axi_read_arbiter_if #(.LEN_W(8)) bus_u ();

  axi_read_arbiter #(.LOCK_UNTIL_RLAST(1'b1), .LEN_W(8)) dut_lock (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_l)
  );

  axi_read_arbiter #(.LOCK_UNTIL_RLAST(1'b0), .LEN_W(8)) dut_rel (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_u)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rst;
    logic [2:0] req;
    logic       arv, ary;
    logic [7:0] len;
    logic       rv, rr, rl;
    logic [2:0] gnt;
    logic       busy, err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, logic [2:0] req, logic arv, logic ary, logic [7:0] len,
                              logic rv, logic rr, logic rl, logic [2:0] gnt, logic busy,
                              logic err);
    vec_t v;
    v.rst = rst; v.req = req; v.arv = arv; v.ary = ary; v.len = len;
    v.rv = rv; v.rr = rr; v.rl = rl; v.gnt = gnt; v.busy = busy; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input bit rel, input string tag, input logic [2:0] g, input logic b,
                            input logic e);
    logic [2:0] ag;
    logic ab, ae;
    if (rel) begin
      ag = {bus_u.m2_rgrnt, bus_u.m1_rgrnt, bus_u.m0_rgrnt}; ab = bus_u.busy; ae = bus_u.len_err;
    end else begin
      ag = {bus_l.m2_rgrnt, bus_l.m1_rgrnt, bus_l.m0_rgrnt}; ab = bus_l.busy; ae = bus_l.len_err;
    end
    check({tag, " gnt"}, {5'd0, ag}, {5'd0, g});
    check({tag, " busy"}, {7'd0, ab}, {7'd0, b});
    check({tag, " len_err"}, {7'd0, ae}, {7'd0, e});
  endtask

  task automatic set_in(input logic [2:0] req, input logic arv, input logic ary,
                        input logic [7:0] len, input logic rv, input logic rr, input logic rl);
    {bus_l.m2_arvalid, bus_l.m1_arvalid, bus_l.m0_arvalid} = req;
    {bus_u.m2_arvalid, bus_u.m1_arvalid, bus_u.m0_arvalid} = req;
    bus_l.arvalid = arv; bus_u.arvalid = arv;
    bus_l.arready = ary; bus_u.arready = ary;
    bus_l.arlen   = len; bus_u.arlen   = len;
    bus_l.rvalid  = rv;  bus_u.rvalid  = rv;
    bus_l.rready  = rr;  bus_u.rready  = rr;
    bus_l.rlast   = rl;  bus_u.rlast   = rl;
  endtask

  task automatic step(input logic [2:0] req, input logic arv, input logic ary,
                      input logic [7:0] len, input logic rv, input logic rr, input logic rl);
    @(negedge clk);
    set_in(req, arv, ary, len, rv, rr, rl);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_in(3'b000, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: who owns the channel, whether the address is still pending,
  // how many beats have arrived, and which master was served last.
  bit lock_mode[2] = '{1'b1, 1'b0};
  int owner[2];
  int last_served[2];
  int beats[2];
  int blen[2];
  bit addr_pending[2];
  bit reported[2];
  bit m_err[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owner[i] = -1; last_served[i] = 2; beats[i] = 0; blen[i] = 0;
      addr_pending[i] = 1'b0; reported[i] = 1'b0; m_err[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i);
    logic [2:0] req;
    req = {bus_l.m2_arvalid, bus_l.m1_arvalid, bus_l.m0_arvalid};
    m_err[i] = 1'b0;
    if (owner[i] < 0) begin
      for (int k = 1; k <= 3; k++) begin
        int cand;
        cand = (last_served[i] + k) % 3;
        if (owner[i] < 0 && req[cand]) begin
          owner[i] = cand; last_served[i] = cand; addr_pending[i] = 1'b1;
        end
      end
    end else if (addr_pending[i]) begin
      if (bus_l.arvalid && bus_l.arready) begin
        blen[i] = int'(bus_l.arlen); beats[i] = 0; reported[i] = 1'b0;
        addr_pending[i] = 1'b0;
        if (!lock_mode[i]) owner[i] = -1;
      end
    end else if (bus_l.rvalid && bus_l.rready) begin
      if (bus_l.rlast) begin
        m_err[i] = !reported[i] && (beats[i] != blen[i]);
        owner[i] = -1;
      end else if (!reported[i] && beats[i] == blen[i]) begin
        m_err[i] = 1'b1; reported[i] = 1'b1;
      end
      beats[i]++;
    end
  endtask

  task automatic model_check(input int i);
    logic [2:0] g;
    g = '0;
    if (owner[i] >= 0) g[owner[i]] = 1'b1;
    check_outs(i == 1, i == 1 ? "rand_rel" : "rand_lock", g, owner[i] >= 0, m_err[i]);
  endtask

  initial begin
    int errs_seen;
    set_in(3'b000, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Idle after reset
    for (int i = 0; i < 10; i++) vecs.push_back(mk(i == 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
    // Single master m1, len 3, with ARVALID drop while waiting for the handshake
    vecs.push_back(mk(1, 3'b010, 0, 0, 0, 0, 0, 0, 3'b010, 1, 0));
    vecs.push_back(mk(0, 3'b010, 1, 0, 3, 0, 0, 0, 3'b010, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 1, 3, 0, 0, 0, 3'b010, 1, 0));
    vecs.push_back(mk(0, 3'b010, 1, 1, 3, 0, 0, 0, 3'b010, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 1, 0, 3'b010, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 1, 0, 3'b010, 1, 0));
    vecs.push_back(mk(0, 3'b101, 0, 0, 0, 1, 0, 0, 3'b010, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 1, 0, 3'b010, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 1, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
    // Contention, len 0 bursts: m0, m1, m2, m0 with one idle cycle between
    vecs.push_back(mk(1, 3'b111, 0, 0, 0, 0, 0, 0, 3'b001, 1, 0));
    vecs.push_back(mk(0, 3'b111, 1, 1, 0, 0, 0, 0, 3'b001, 1, 0));
    vecs.push_back(mk(0, 3'b111, 0, 0, 0, 1, 1, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b111, 0, 0, 0, 0, 0, 0, 3'b010, 1, 0));
    vecs.push_back(mk(0, 3'b111, 1, 1, 0, 0, 0, 0, 3'b010, 1, 0));
    vecs.push_back(mk(0, 3'b111, 0, 0, 0, 1, 1, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b111, 0, 0, 0, 0, 0, 0, 3'b100, 1, 0));
    vecs.push_back(mk(0, 3'b111, 1, 1, 0, 0, 0, 0, 3'b100, 1, 0));
    vecs.push_back(mk(0, 3'b111, 0, 0, 0, 1, 1, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b111, 0, 0, 0, 0, 0, 0, 3'b001, 1, 0));
    // Short burst: len 3, RLAST on 2nd beat
    vecs.push_back(mk(1, 3'b001, 0, 0, 0, 0, 0, 0, 3'b001, 1, 0));
    vecs.push_back(mk(0, 3'b001, 1, 1, 3, 0, 0, 0, 3'b001, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 1, 0, 3'b001, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 1, 1, 3'b000, 0, 1));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
    // Long burst: len 1, RLAST on 4th beat
    vecs.push_back(mk(1, 3'b100, 0, 0, 0, 0, 0, 0, 3'b100, 1, 0));
    vecs.push_back(mk(0, 3'b100, 1, 1, 1, 0, 0, 0, 3'b100, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 1, 0, 3'b100, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 1, 0, 3'b100, 1, 1));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 1, 0, 3'b100, 1, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 1, 1, 1, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        do_reset();
        check_outs(1'b0, "reset", 3'b000, 1'b0, 1'b0);
      end
      step(vecs[i].req, vecs[i].arv, vecs[i].ary, vecs[i].len, vecs[i].rv, vecs[i].rr,
           vecs[i].rl);
      check_outs(1'b0, $sformatf("vec%0d", i), vecs[i].gnt, vecs[i].busy, vecs[i].err);
    end

    // 256-beat burst with len 255 is clean
    do_reset();
    step(3'b001, 0, 0, 0, 0, 0, 0);
    step(3'b000, 1, 1, 8'd255, 0, 0, 0);
    errs_seen = 0;
    for (int k = 0; k < 255; k++) begin
      step(3'b000, 0, 0, 0, 1, 1, 0);
      if (bus_l.len_err) errs_seen++;
    end
    check("len255 no early err", 8'(errs_seen), 8'd0);
    check_outs(1'b0, "len255 held", 3'b001, 1'b1, 1'b0);
    step(3'b000, 0, 0, 0, 1, 1, 1);
    check_outs(1'b0, "len255 last", 3'b000, 1'b0, 1'b0);

    // 257 beats with len 255: exactly one error pulse despite the saturated counter
    step(3'b010, 0, 0, 0, 0, 0, 0);
    step(3'b000, 1, 1, 8'd255, 0, 0, 0);
    errs_seen = 0;
    for (int k = 0; k < 256; k++) begin
      step(3'b000, 0, 0, 0, 1, 1, 0);
      if (bus_l.len_err) errs_seen++;
    end
    step(3'b000, 0, 0, 0, 1, 1, 1);
    if (bus_l.len_err) errs_seen++;
    check("overrun single err", 8'(errs_seen), 8'd1);
    check_outs(1'b0, "overrun last", 3'b000, 1'b0, 1'b0);

    // Asynchronous reset mid-burst, then pointer back at m0
    do_reset();
    step(3'b010, 0, 0, 0, 0, 0, 0);
    step(3'b000, 1, 1, 8'd3, 0, 0, 0);
    step(3'b000, 0, 0, 0, 1, 1, 0);
    check_outs(1'b0, "pre_rst", 3'b010, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_outs(1'b0, "async_rst", 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b110, 0, 0, 0, 0, 0, 0);
    check_outs(1'b0, "post_rst pick", 3'b010, 1'b1, 1'b0);

    // Release-after-AR mode
    do_reset();
    step(3'b001, 0, 0, 0, 0, 0, 0);
    check_outs(1'b1, "rel grant", 3'b001, 1'b1, 1'b0);
    step(3'b000, 1, 1, 8'd3, 0, 0, 0);
    check_outs(1'b1, "rel drop", 3'b000, 1'b0, 1'b0);
    step(3'b000, 0, 0, 0, 1, 1, 1);
    check_outs(1'b1, "rel beat", 3'b000, 1'b0, 1'b0);
    step(3'b011, 0, 0, 0, 0, 0, 0);
    check_outs(1'b1, "rel rotate", 3'b010, 1'b1, 1'b0);

    // Randomized run against the model, both lock modes
    do_reset();
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        do_reset();
        model_reset();
        check_outs(1'b0, "rand reset", 3'b000, 1'b0, 1'b0);
      end
      @(negedge clk);
      set_in(3'($urandom_range(0, 7)), $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) == 0);
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      model_check(0);
      model_check(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
